// File: rtl/system_memory_v4_if.sv
// system_memory_v4_if: bus between the cell-update logic / serial host (master) and the grid memory (slave)
//   grid_in        next-generation grid, parallel
//   serial_in      serial load bit
//   load_mode      select serial load
//   run_mode       select parallel capture
//   output_mode    select rotating serial readout
//   system_mem_out current memory contents
//   serial_out     registered serial readout bit
interface system_memory_v4_if #(parameter int DATA_SIZE = 5);
  logic [DATA_SIZE-1:0] grid_in;
  logic                 serial_in;
  logic                 load_mode;
  logic                 run_mode;
  logic                 output_mode;
  logic [DATA_SIZE-1:0] system_mem_out;
  logic                 serial_out;
  modport master (
    output grid_in, serial_in, load_mode, run_mode, output_mode,
    input  system_mem_out, serial_out
  );
  modport slave (
    input  grid_in, serial_in, load_mode, run_mode, output_mode,
    output system_mem_out, serial_out
  );
endinterface

// File: rtl/system_memory_v4.sv
// system_memory_v4: Game-of-Life grid register with parallel capture, serial load and rotating serial readout
//   clk  rising-edge clock
//   rst  asynchronous active-high reset, clears memory and serial_out
//   bus  system_memory_v4_if.slave (mode selects, grid/serial data in, memory/serial data out)
module system_memory_v4 #(
  parameter int DATA_SIZE = 5
) (
  input logic                clk,
  input logic                rst,
  system_memory_v4_if.slave  bus
);
  logic [DATA_SIZE-1:0] mem;
  logic [DATA_SIZE-1:0] mem_next;
  logic                 ser_next;
  // Priority: run > load > output > hold; serial_out is only nonzero after a rotate.
  always_comb begin
    mem_next = bus.run_mode    ? bus.grid_in :
               bus.load_mode   ? {mem[DATA_SIZE-2:0], bus.serial_in} :
               bus.output_mode ? {mem[DATA_SIZE-2:0], mem[DATA_SIZE-1]} : mem;
    ser_next = !bus.run_mode && !bus.load_mode && bus.output_mode && mem[DATA_SIZE-1];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem            <= '0;
      bus.serial_out <= 1'b0;
    end else begin
      mem            <= mem_next;
      bus.serial_out <= ser_next;
    end
  assign bus.system_mem_out = mem;
endmodule

// File: tb/tb_system_memory_v4.sv
// tb_system_memory_v4: directed self-checking bench for system_memory_v4
module tb_system_memory_v4;
  localparam int N = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  system_memory_v4_if #(.DATA_SIZE(N)) bus ();
  system_memory_v4 #(.DATA_SIZE(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic modes(input logic run, input logic load, input logic out);
    bus.run_mode    = run;
    bus.load_mode   = load;
    bus.output_mode = out;
  endtask
  task automatic expect_state(input string tag, input logic [N-1:0] m, input logic s);
    check({tag, " mem"}, 32'(bus.system_mem_out), 32'(m));
    check({tag, " ser"}, 32'(bus.serial_out), 32'(s));
  endtask
  task automatic pulse_reset();
    rst = 1'b1;
    #1;
  endtask
  logic [N-1:0] load_mem [4] = '{5'b00001, 5'b00010, 5'b00100, 5'b01001};
  logic         load_bit [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [N-1:0] rot_mem  [5] = '{5'b11010, 5'b10101, 5'b01011, 5'b10110, 5'b01101};
  logic         rot_ser  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  initial begin
    bus.grid_in   = 5'b11001;
    bus.serial_in = 1'b1;
    modes(0, 0, 0);
    #12;
    expect_state("reset", 5'b00000, 1'b0);
    rst = 1'b0;
    step();
    expect_state("idle_after_reset", 5'b00000, 1'b0);
    modes(0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      bus.serial_in = load_bit[i];
      step();
      expect_state($sformatf("load%0d", i), load_mem[i], 1'b0);
    end
    modes(1, 1, 0);
    bus.grid_in = 5'b00110;
    step();
    expect_state("run_over_load", 5'b00110, 1'b0);
    modes(0, 0, 0);
    bus.grid_in = 5'b11111;
    step();
    step();
    expect_state("hold", 5'b00110, 1'b0);
    pulse_reset();
    expect_state("async_reset", 5'b00000, 1'b0);
    rst = 1'b0;
    modes(1, 0, 0);
    bus.grid_in = 5'b01101;
    step();
    expect_state("run_load", 5'b01101, 1'b0);
    modes(0, 0, 1);
    bus.grid_in = 5'b00000;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_state($sformatf("rot%0d", i), rot_mem[i], rot_ser[i]);
    end
    step();
    expect_state("rot_wrap", 5'b11010, 1'b0);
    step();
    expect_state("rot_msb_one", 5'b10101, 1'b1);
    modes(0, 0, 0);
    step();
    expect_state("ser_clears_on_hold", 5'b10101, 1'b0);
    pulse_reset();
    rst = 1'b0;
    modes(0, 1, 1);
    bus.serial_in = 1'b1;
    step();
    expect_state("load_over_output", 5'b00001, 1'b0);
    modes(1, 1, 0);
    bus.grid_in = 5'b11011;
    step();
    expect_state("run_over_load2", 5'b11011, 1'b0);
    modes(1, 0, 1);
    bus.grid_in = 5'b00110;
    step();
    expect_state("run_over_output", 5'b00110, 1'b0);
    modes(1, 0, 0);
    bus.grid_in = 5'b10000;
    step();
    modes(0, 0, 1);
    step();
    expect_state("pre_mid_reset", 5'b00001, 1'b1);
    pulse_reset();
    expect_state("mid_readout_reset", 5'b00000, 1'b0);
    step();
    expect_state("reset_held", 5'b00000, 1'b0);
    rst = 1'b0;
    step();
    expect_state("rotate_zero", 5'b00000, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
